// File: rtl/heading_cal_seq.sv
// heading_cal_seq
// ----------------------------------------------------------------------------
// Sequences calibration of the gyro heading integrator.
//
// A calibration request from the command processor starts the sequence. The
// block waits until the motors have been quiet for SETTLE_CYCS consecutive
// cycles and then issues a one-cycle start pulse to the integrator. It then
// waits up to TMO_CYCS cycles for the completion pulse. A timeout is retried
// up to MAX_RETRY times before the sequence ends in a sticky error. After a
// good calibration the block passes motion control's go request through,
// delayed by one cycle, as the integrator's integrate-enable.
//
// Ports
//   clk          in   system clock
//   rst_n        in   synchronous, active-low reset
//   cal_req      in   calibration request pulse from cmd_proc
//   mtr_active   in   high while either motor drive is nonzero
//   go_in        in   motion control wants heading integrated
//   cal_done     in   one-cycle completion pulse from the integrator
//   strt_cal     out  one-cycle start pulse to the integrator
//   moving       out  integrate-enable to the integrator
//   cal_busy     out  calibration sequence in progress
//   cal_ok       out  calibrated and running (level)
//   cal_err      out  calibration failed; held until the next cal_req
//   retry_cnt    out  retries consumed in the current sequence
//   dbg_state_o  out  current FSM state for debug/checkers
//                     (0 IDLE, 1 SETTLE, 2 START, 3 WAIT_CAL, 4 RUN, 5 ERR)
//
// Every output is a flop. The output process decodes the *next* state so
// that each registered output lines up with the state register.
// ----------------------------------------------------------------------------
module heading_cal_seq #(
    parameter int SETTLE_CYCS = 16,
    parameter int TMO_CYCS    = 1024,
    parameter int MAX_RETRY   = 2     // retry_cnt is 2 bits: keep <= 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cal_req,
    input  logic       mtr_active,
    input  logic       go_in,
    input  logic       cal_done,
    output logic       strt_cal,
    output logic       moving,
    output logic       cal_busy,
    output logic       cal_ok,
    output logic       cal_err,
    output logic [1:0] retry_cnt,
    output logic [2:0] dbg_state_o
);

    // Counter widths hold exactly the terminal value (N-1).
    localparam int SW = (SETTLE_CYCS > 1) ? $clog2(SETTLE_CYCS) : 1;
    localparam int TW = (TMO_CYCS > 1) ? $clog2(TMO_CYCS) : 1;

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCS - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TMO_CYCS - 1);
    localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE   = 3'd1,
        START    = 3'd2,
        WAIT_CAL = 3'd3,
        RUN      = 3'd4,
        ERR      = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    retry_q, retry_d;

    logic strt_cal_q, strt_cal_d;
    logic moving_q, moving_d;
    logic cal_busy_q, cal_busy_d;
    logic cal_ok_q, cal_ok_d;
    logic cal_err_q, cal_err_d;

    logic settle_last;
    logic tmo_last;

    assign settle_last = (settle_q == SETTLE_LAST);
    assign tmo_last    = (tmo_q == TMO_LAST);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            settle_q   <= '0;
            tmo_q      <= '0;
            retry_q    <= '0;
            strt_cal_q <= 1'b0;
            moving_q   <= 1'b0;
            cal_busy_q <= 1'b0;
            cal_ok_q   <= 1'b0;
            cal_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            tmo_q      <= tmo_d;
            retry_q    <= retry_d;
            strt_cal_q <= strt_cal_d;
            moving_q   <= moving_d;
            cal_busy_q <= cal_busy_d;
            cal_ok_q   <= cal_ok_d;
            cal_err_q  <= cal_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        retry_d  = retry_q;

        case (state_q)
            IDLE: begin
                if (cal_req) begin
                    retry_d  = '0;
                    settle_d = '0;
                    state_d  = SETTLE;
                end
            end

            SETTLE: begin
                // Any motor activity restarts the quiet window. The counter
                // holds at its terminal value; leaving for START ends it.
                if (mtr_active) begin
                    settle_d = '0;
                end else if (settle_last) begin
                    state_d = START;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end

            START: begin
                tmo_d   = '0;
                state_d = WAIT_CAL;
            end

            WAIT_CAL: begin
                // A completion beats both a same-cycle timeout and motor
                // activity. Motor activity aborts the attempt without
                // consuming a retry.
                if (cal_done) begin
                    state_d = RUN;
                end else if (mtr_active) begin
                    settle_d = '0;
                    state_d  = SETTLE;
                end else if (tmo_last) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d  = retry_q + 1'b1;
                        settle_d = '0;
                        state_d  = SETTLE;
                    end else begin
                        state_d = ERR;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            RUN, ERR: begin
                // A fresh request restarts the whole sequence; cal_err falls
                // with the state change.
                if (cal_req) begin
                    retry_d  = '0;
                    settle_d = '0;
                    state_d  = SETTLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (registered above)
    // ------------------------------------------------------------------
    always_comb begin
        strt_cal_d = 1'b0;
        moving_d   = 1'b0;
        cal_busy_d = 1'b0;
        cal_ok_d   = 1'b0;
        cal_err_d  = 1'b0;

        case (state_d)
            SETTLE:   cal_busy_d = 1'b1;
            START: begin
                cal_busy_d = 1'b1;
                strt_cal_d = 1'b1;
            end
            WAIT_CAL: cal_busy_d = 1'b1;
            RUN: begin
                cal_ok_d = 1'b1;
                // go_in sampled here reaches the integrator one cycle later.
                moving_d = go_in;
            end
            ERR:      cal_err_d = 1'b1;
            default: begin
                strt_cal_d = 1'b0;
            end
        endcase
    end

    assign strt_cal    = strt_cal_q;
    assign moving      = moving_q;
    assign cal_busy    = cal_busy_q;
    assign cal_ok      = cal_ok_q;
    assign cal_err     = cal_err_q;
    assign retry_cnt   = retry_q;
    assign dbg_state_o = state_q;

endmodule
